// File: rtl/cpu_bus_responder_pkg.sv
// Shared CPU data-port encodings: access types, responder states, slave count.
// Used by the cpu stages, the responder and the memory-mapped slaves.
package cpu_bus_responder_pkg;

  localparam int NUM_SLAVES = 4;

  localparam logic [1:0] DRW_IDLE  = 2'b00;
  localparam logic [1:0] DRW_READ  = 2'b01;
  localparam logic [1:0] DRW_WRITE = 2'b10;
  localparam logic [1:0] DRW_ILL   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Decoded view of one CPU data access.
  typedef struct packed {
    logic [1:0]            idx;
    logic [NUM_SLAVES-1:0] onehot;
    logic                  ok;
    logic                  err;
  } dec_t;

  function automatic logic [NUM_SLAVES-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NUM_SLAVES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cpu_bus_decode.sv
// Combinational slave decode of a CPU data access: select index, one-hot, ok/err flags.
// Zero latency, no flow control; only the address bits from SEL_LSB upward are seen.
module cpu_bus_decode
  import cpu_bus_responder_pkg::*;
#(
  parameter int SEL_LSB = 28
) (
  input  logic [31-SEL_LSB:0] addr_hi,
  input  logic [1:0]          drw,
  output dec_t                dec
);

  logic mapped;
  logic is_rw;

  // With the select field at the very top of the address there is nothing to be unmapped.
  generate
    if (SEL_LSB <= 29) begin : g_hi
      assign mapped = (addr_hi[31-SEL_LSB:2] == '0);
    end else begin : g_nohi
      assign mapped = 1'b1;
    end
  endgenerate

  assign is_rw = (drw == DRW_READ) || (drw == DRW_WRITE);

  always_comb begin
    dec.idx    = addr_hi[1:0];
    dec.onehot = idx_to_onehot(addr_hi[1:0]);
    dec.ok     = is_rw && mapped;
    dec.err    = (drw != DRW_IDLE) && !(is_rw && mapped);
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU data-port responder: decodes each access to one of four slaves over a level req/ack.
// Stalls the CPU from the access cycle until one DONE cycle after ack, error or timeout.
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  daddr,
  input  logic [31:0]  dout,
  input  logic [1:0]   drw,
  output logic [31:0]  din,
  output logic         cpu_stall,
  output logic [3:0]   s_req,
  output logic         s_we,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  input  logic [127:0] s_rdata,
  input  logic [3:0]   s_ack,
  output logic         bus_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [1:0]      idx_q;
  logic [TO_W-1:0] to_cnt;
  dec_t            dec;
  logic            ack_hit;
  logic [31:0]     rdata_sel;

  cpu_bus_decode #(
    .SEL_LSB (SEL_LSB)
  ) u_decode (
    .addr_hi (daddr[31:SEL_LSB]),
    .drw     (drw),
    .dec     (dec)
  );

  // Combinational so the CPU freezes in the same cycle the access appears.
  assign cpu_stall = ((state == ST_IDLE) && (drw != DRW_IDLE)) || (state == ST_WAIT);

  assign ack_hit   = s_ack[idx_q];
  assign rdata_sel = s_rdata[{idx_q, 5'd0} +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      to_cnt  <= '0;
      din     <= '0;
      s_req   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dec.ok) begin
            s_addr  <= daddr;
            s_wdata <= dout;
            s_we    <= drw[1];
            s_req   <= dec.onehot;
            idx_q   <= dec.idx;
            to_cnt  <= '0;
            state   <= ST_WAIT;
          end else if (dec.err) begin
            din     <= '0;
            bus_err <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_WAIT: begin
          // An ack landing on the last allowed cycle still wins over the timeout.
          if (ack_hit) begin
            din   <= s_we ? 32'd0 : rdata_sel;
            s_req <= '0;
            state <= ST_DONE;
          end else if (to_cnt == TO_LAST) begin
            din     <= '0;
            s_req   <= '0;
            bus_err <= 1'b1;
            state   <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
